// File: rtl/counter_pkg.sv
// Shared defaults and boundary-mode encoding for the prescaled counter family.
package counter_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 8;
  localparam int unsigned PRE_W_DEF     = 4;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

endpackage

// File: rtl/clk_prescaler.sv
// Clock-enable prescaler: pulses tick once every pre_div+1 enabled cycles.
module clk_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRE_W = PRE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] pre_div,
  output logic             tick
);

  localparam logic [PRE_W-1:0] PRE_ONE = {{(PRE_W-1){1'b0}}, 1'b1};

  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;

  // A lowered pre_div below pre_cnt just lets the counter run round to it.
  always_comb begin
    tick = en & (pre_cnt_q == pre_div);
  end

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clr) begin
      pre_cnt_d = '0;
    end else if (tick) begin
      pre_cnt_d = '0;
    end else if (en) begin
      pre_cnt_d = pre_cnt_q + PRE_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/prescaled_mod_counter.sv
// Up/down modulo counter stepped by a prescaler, with load, wrap/saturate
// boundary handling, a terminal-count pulse and a sticky overflow flag.
module prescaled_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH     = CNT_WIDTH_DEF,
  parameter int unsigned     PRE_W     = PRE_W_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [PRE_W-1:0] pre_div,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             tick
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             boundary;
  cnt_mode_e        mode;

  clk_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (load),
    .pre_div (pre_div),
    .tick    (tick)
  );

  always_comb begin
    mode     = cnt_mode_e'(sat_mode);
    count_d  = count_q;
    boundary = 1'b0;
    if (load) begin
      count_d = (load_val > limit) ? limit : load_val;
    end else if (tick) begin
      if (up) begin
        // >= so a limit lowered beneath the current count still wraps/saturates
        if (count_q < limit) begin
          count_d = count_q + CNT_ONE;
        end else begin
          boundary = 1'b1;
          count_d  = (mode == CNT_SAT) ? limit : '0;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - CNT_ONE;
        end else begin
          boundary = 1'b1;
          count_d  = (mode == CNT_SAT) ? '0 : limit;
        end
      end
    end
  end

  // A boundary step on the same cycle as clr_ovf keeps the flag set.
  always_comb begin
    tc_d  = boundary;
    ovf_d = boundary | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RESET_VAL;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule
